// File: rtl/serpent_cipher.sv
// serpent_cipher: iterative bitsliced Serpent (256-bit key, 128-bit block).
// One round per clock, with the key schedule generated on the fly from an
// 8-word prekey window.
//   i_clk, i_resetn        clock, asynchronous active-low reset
//   i_dir                  1 = encrypt (32 clocks), 0 = decrypt (64 clocks)
//   i_key[255:0]           user key, w[-8] = i_key[31:0]
//   i_new_block, i_data    start pulse and input block (X0 = i_data[31:0])
//   o_ready, o_output      idle/result-valid flag and result block
module serpent_cipher #(
  parameter int ENC_LATENCY = 32,
  parameter int DEC_LATENCY = 64
) (
  input  logic         i_clk,
  input  logic         i_resetn,
  input  logic         i_dir,
  input  logic [255:0] i_key,
  input  logic         i_new_block,
  input  logic [127:0] i_data,
  output logic         o_ready,
  output logic [127:0] o_output
);
  localparam logic [31:0] PHI = 32'h9E3779B9;

  typedef logic [3:0][31:0] blk_t;  // [0] = X0
  typedef logic [7:0][31:0] win_t;  // [0] = oldest prekey

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Entry x of S-box s lives in nibble x of the row constant.
  function automatic logic [3:0] sbox(input logic [2:0] s, input logic [3:0] x);
    logic [63:0] row;
    case (s)
      3'd0:    row = 64'hC90724DEB56A1F83;
      3'd1:    row = 64'h43D68EB1A50972CF;
      3'd2:    row = 64'h25B04E1DFAC39768;
      3'd3:    row = 64'hE57A421D369C8BF0;
      3'd4:    row = 64'hD7E9A4526B0C38F1;
      3'd5:    row = 64'h176D8E30C9A4B25F;
      3'd6:    row = 64'h0A3DF19EB6485C27;
      default: row = 64'h6539AC47B28E0FD1;
    endcase
    return row[{x, 2'b00} +: 4];
  endfunction

  // Inverse by search over the forward table keeps a single source of truth.
  function automatic logic [3:0] sbox_inv(input logic [2:0] s, input logic [3:0] y);
    logic [3:0] r;
    r = 4'd0;
    for (int v = 0; v < 16; v++)
      if (sbox(s, 4'(v)) == y) r = 4'(v);
    return r;
  endfunction

  // Bitsliced S-box layer: bit i of the four words forms one nibble, X0 = LSB.
  function automatic blk_t slice(input logic [2:0] s, input blk_t b, input logic inv);
    blk_t       o;
    logic [3:0] x;
    logic [3:0] y;
    o = '0;
    for (int i = 0; i < 32; i++) begin
      x = {b[3][i], b[2][i], b[1][i], b[0][i]};
      y = inv ? sbox_inv(s, x) : sbox(s, x);
      for (int m = 0; m < 4; m++) o[m][i] = y[m];
    end
    return o;
  endfunction

  function automatic blk_t lt(input blk_t b);
    logic [31:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = b;
    x0 = rol(x0, 13);
    x2 = rol(x2, 3);
    x1 = x1 ^ x0 ^ x2;
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rol(x1, 1);
    x3 = rol(x3, 7);
    x0 = x0 ^ x1 ^ x3;
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rol(x0, 5);
    x2 = rol(x2, 22);
    return {x3, x2, x1, x0};
  endfunction

  function automatic blk_t ltinv(input blk_t b);
    logic [31:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = b;
    x2 = ror(x2, 22);
    x0 = ror(x0, 5);
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = x0 ^ x1 ^ x3;
    x3 = ror(x3, 7);
    x1 = ror(x1, 1);
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = x1 ^ x0 ^ x2;
    x2 = ror(x2, 3);
    x0 = ror(x0, 13);
    return {x3, x2, x1, x0};
  endfunction

  // win = w[b-8..b-1]; returns w[b..b+3].
  function automatic blk_t fwd4(input win_t win, input logic [31:0] b);
    logic [31:0] t [12];
    for (int k = 0; k < 8; k++) t[k] = win[k];
    for (int k = 0; k < 4; k++)
      t[8+k] = rol(t[k] ^ t[k+3] ^ t[k+5] ^ t[k+7] ^ PHI ^ (b + 32'(k)), 11);
    return {t[11], t[10], t[9], t[8]};
  endfunction

  // win = w[i0-4..i0+3]; returns w[i0-8..i0-5]. Highest word first, since
  // w[i0-8] needs the freshly recovered w[i0-5].
  function automatic blk_t bwd4(input win_t win, input logic [31:0] i0);
    logic [31:0] t [12];
    for (int k = 0; k < 8; k++) t[4+k] = win[k];
    for (int k = 3; k >= 0; k--)
      t[k] = ror(t[k+8], 11) ^ t[k+3] ^ t[k+5] ^ t[k+7] ^ PHI ^ (i0 + 32'(k));
    return {t[3], t[2], t[1], t[0]};
  endfunction

  logic [6:0] c_q, c_d;
  logic       rdy_q, rdy_d;
  blk_t       blk_q, blk_d;
  win_t       win_q, win_d;

  logic [4:0] r_e, r_d;
  logic       busy;
  blk_t       fw, bw, kr, k32, t;
  win_t       win_fw, kwin;

  // Encrypt round (and decrypt forward phase) at c is c-1; inverse round is 64-c.
  assign r_e    = 5'(c_q - 7'd1);
  assign r_d    = 5'(7'(DEC_LATENCY) - c_q);
  assign busy   = !rdy_q && (c_q != 7'd0);

  // Forward: window w[4r-8..4r-1] -> new words w[4r..4r+3] are K_r's prekeys.
  assign fw     = fwd4(win_q, {25'd0, r_e, 2'b00});
  assign win_fw = {fw, win_q[7:4]};
  // Backward: window w[4r-4..4r+3]; K_r's prekeys are the upper half.
  assign bw     = bwd4(win_q, {25'd0, r_d, 2'b00});

  // K_32 is only consumed in round 31, where either window reaches w[120..127].
  assign kwin   = i_dir ? win_fw : win_q;
  assign k32    = slice(3'd3, fwd4(kwin, 32'd128), 1'b0);
  assign kr     = i_dir ? slice(3'd3 - r_e[2:0], fw, 1'b0)
                        : slice(3'd3 - r_d[2:0], win_q[7:4], 1'b0);

  always_comb begin
    c_d   = c_q;
    rdy_d = rdy_q;
    blk_d = blk_q;
    win_d = win_q;
    t     = blk_q;
    if (i_new_block) begin
      c_d   = 7'd1;
      rdy_d = 1'b0;
      blk_d = i_data;
      win_d = i_key;
    end else if (busy) begin
      if (i_dir) begin
        t     = slice(r_e[2:0], blk_q ^ kr, 1'b0);
        t     = (r_e == 5'd31) ? (t ^ k32) : lt(t);
        blk_d = t;
        win_d = win_fw;
      end else if (c_q <= 7'(ENC_LATENCY)) begin
        // Walk the prekeys up to w[120..127]; data stays put.
        win_d = win_fw;
      end else begin
        if (r_d == 5'd31) t = slice(3'd7, blk_q ^ k32, 1'b1);
        else              t = slice(r_d[2:0], ltinv(blk_q), 1'b1);
        blk_d = t ^ kr;
        win_d = {win_q[3:0], bw};
      end
      if (c_q == (i_dir ? 7'(ENC_LATENCY) : 7'(DEC_LATENCY))) rdy_d = 1'b1;
      else                                                   c_d   = c_q + 7'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      c_q   <= 7'd0;
      rdy_q <= 1'b1;
      blk_q <= '0;
      win_q <= '0;
    end else begin
      c_q   <= c_d;
      rdy_q <= rdy_d;
      blk_q <= blk_d;
      win_q <= win_d;
    end
  end

  assign o_ready  = rdy_q;
  assign o_output = blk_q;

endmodule

// File: tb/tb_serpent_cipher.sv
// tb_serpent_cipher: checks serpent_cipher against a plain array-based Serpent
// model (full key schedule precomputed, table S-boxes, inverse by search).
module tb_serpent_cipher;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         dir = 1'b1;
  logic         nb = 1'b0;
  logic [255:0] key = '0;
  logic [127:0] din = '0;
  logic         rdy;
  logic [127:0] dout;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  serpent_cipher dut (
    .i_clk      (clk),
    .i_resetn   (rstn),
    .i_dir      (dir),
    .i_key      (key),
    .i_new_block(nb),
    .i_data     (din),
    .o_ready    (rdy),
    .o_output   (dout)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int SB [8][16] = '{
    '{ 3, 8,15, 1,10, 6, 5,11,14,13, 4, 2, 7, 0, 9,12},
    '{15,12, 2, 7, 9, 0, 5,10, 1,11,14, 8, 6,13, 3, 4},
    '{ 8, 6, 7, 9, 3,12,10,15,13, 1,14, 4, 0,11, 5, 2},
    '{ 0,15,11, 8,12, 9, 6, 3,13, 1, 2, 4,10, 7, 5,14},
    '{ 1,15, 8, 3,12, 0,11, 6, 2, 5, 4,10, 9,14, 7,13},
    '{15, 5, 2,11, 4,10, 9,12, 0, 3,14, 8,13, 6, 7, 1},
    '{ 7, 2,12, 5, 8, 4, 6,11,14, 9, 1,15,13, 3,10, 0},
    '{ 1,13,15, 0,14, 8, 2,11, 7, 4,12,10, 9, 3, 5, 6}
  };

  logic [127:0] KS [33];

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [127:0] sapply(input int s, input logic [127:0] b, input bit inv);
    logic [127:0] o;
    logic [3:0]   nib;
    logic [3:0]   y;
    o = '0;
    for (int i = 0; i < 32; i++) begin
      nib = {b[96+i], b[64+i], b[32+i], b[i]};
      y = 4'd0;
      if (!inv) y = 4'(SB[s][nib]);
      else for (int v = 0; v < 16; v++) if (SB[s][v] == int'(nib)) y = 4'(v);
      o[i] = y[0]; o[32+i] = y[1]; o[64+i] = y[2]; o[96+i] = y[3];
    end
    return o;
  endfunction

  function automatic logic [127:0] lt_m(input logic [127:0] b);
    logic [31:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = b;
    x0 = rol(x0, 13); x2 = rol(x2, 3);
    x1 = x1 ^ x0 ^ x2; x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rol(x1, 1); x3 = rol(x3, 7);
    x0 = x0 ^ x1 ^ x3; x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rol(x0, 5); x2 = rol(x2, 22);
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [127:0] ltinv_m(input logic [127:0] b);
    logic [31:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = b;
    x2 = ror(x2, 22); x0 = ror(x0, 5);
    x2 = x2 ^ x3 ^ (x1 << 7); x0 = x0 ^ x1 ^ x3;
    x3 = ror(x3, 7); x1 = ror(x1, 1);
    x3 = x3 ^ x2 ^ (x0 << 3); x1 = x1 ^ x0 ^ x2;
    x2 = ror(x2, 3); x0 = ror(x0, 13);
    return {x3, x2, x1, x0};
  endfunction

  // w[k-8] is stored at index k.
  task automatic build_ks(input logic [255:0] k);
    logic [31:0] w [140];
    for (int i = 0; i < 8; i++) w[i] = k[32*i +: 32];
    for (int i = 0; i < 132; i++)
      w[i+8] = rol(w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7] ^ 32'h9E3779B9 ^ 32'(i), 11);
    for (int j = 0; j < 33; j++)
      KS[j] = sapply((3 - j) & 7, {w[4*j+11], w[4*j+10], w[4*j+9], w[4*j+8]}, 1'b0);
  endtask

  function automatic logic [127:0] enc_m(input logic [127:0] x);
    logic [127:0] b;
    b = x;
    for (int r = 0; r < 32; r++) begin
      b = sapply(r % 8, b ^ KS[r], 1'b0);
      b = (r < 31) ? lt_m(b) : (b ^ KS[32]);
    end
    return b;
  endfunction

  function automatic logic [127:0] dec_m(input logic [127:0] x);
    logic [127:0] b;
    b = sapply(7, x ^ KS[32], 1'b1) ^ KS[31];
    for (int r = 30; r >= 0; r--)
      b = sapply(r % 8, ltinv_m(b), 1'b1) ^ KS[r];
    return b;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic start(input bit d, input logic [255:0] k, input logic [127:0] x);
    @(negedge clk);
    dir = d; key = k; din = x; nb = 1'b1;
    @(negedge clk);
    nb = 1'b0;
    din = {$urandom, $urandom, $urandom, $urandom};
    chk("busy_after_start", 128'(rdy), 128'(0));
  endtask

  // Counts rising edges after the start edge until o_ready, bounded.
  task automatic wait_done(input int exp_lat, output logic [127:0] res);
    int n;
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (rdy) break;
    end
    chk("latency", 128'(n), 128'(exp_lat));
    res = dout;
  endtask

  task automatic run(input bit d, input logic [255:0] k, input logic [127:0] x,
                     output logic [127:0] res);
    start(d, k, x);
    wait_done(d ? 32 : 64, res);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [255:0] k0, kr;
    logic [127:0] ct [100];
    logic [127:0] r, a, b, x;

    k0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    // reset
    rstn = 1'b0;
    #200;
    chk("rst_ready", 128'(rdy), 128'(1));
    chk("rst_output", dout, '0);
    @(negedge clk); rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_ready", 128'(rdy), 128'(1));
    chk("idle_output", dout, '0);

    // encrypt sweep and decrypt round trip
    build_ks(k0);
    for (int i = 0; i < 100; i++) begin
      run(1'b1, k0, 128'(i), r);
      ct[i] = r;
      chk("enc_sweep", r, enc_m(128'(i)));
    end
    for (int i = 0; i < 100; i++) begin
      run(1'b0, k0, ct[i], r);
      chk("dec_sweep", r, 128'(i));
    end

    // output holds while idle regardless of i_data
    repeat (5) begin
      @(negedge clk); din = {$urandom, $urandom, $urandom, $urandom};
    end
    chk("hold_ready", 128'(rdy), 128'(1));
    chk("hold_output", dout, 128'(99));

    // restart while busy at c=10
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    start(1'b1, k0, a);
    repeat (8) @(negedge clk);
    start(1'b1, k0, b);
    wait_done(32, r);
    chk("restart_out", r, enc_m(b));

    // start held high for two edges: last sampled block wins
    @(negedge clk); dir = 1'b1; key = k0; din = a; nb = 1'b1;
    @(negedge clk); din = b;
    chk("held_busy", 128'(rdy), 128'(0));
    @(negedge clk); nb = 1'b0;
    chk("held_busy2", 128'(rdy), 128'(0));
    wait_done(32, r);
    chk("held_out", r, enc_m(b));

    // asynchronous reset at c=20
    start(1'b1, k0, a);
    repeat (19) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_ready", 128'(rdy), 128'(1));
    chk("midrst_output", dout, '0);
    @(negedge clk); rstn = 1'b1;
    run(1'b1, k0, a, r);
    chk("after_rst_enc", r, enc_m(a));

    // all-ones key and data
    build_ks('1);
    run(1'b1, '1, '1, r);
    chk("ones_enc", r, enc_m('1));
    run(1'b0, '1, r, r);
    chk("ones_dec", r, '1);

    // random keys and blocks, both directions
    for (int it = 0; it < 8; it++) begin
      for (int m = 0; m < 8; m++) kr[32*m +: 32] = $urandom;
      x = {$urandom, $urandom, $urandom, $urandom};
      build_ks(kr);
      run(1'b1, kr, x, r);
      chk("rand_enc", r, enc_m(x));
      run(1'b0, kr, x, r);
      chk("rand_dec", r, dec_m(x));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
